// File: rtl/memory_pkg.sv
// Shared types for the MEM stage: bus words, register numbers, the
// execute->memory slot, the write-back packet and the data-bus structs.
package memory_pkg;

  localparam int unsigned XLEN_W   = 32;
  localparam int unsigned REG_AW_W = 5;

  typedef logic [XLEN_W-1:0]   u32;
  typedef logic [REG_AW_W-1:0] creg_addr_t;
  typedef logic [3:0]          strobe_t;

  localparam strobe_t STROBE_WORD = 4'b1111;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    DONE
  } mem_state_t;

  typedef struct packed {
    logic       valid;
    logic       mem_to_reg;
    logic       mem_write;
    logic       reg_write;
    logic       reg_dst;
    u32         alu_result;
    u32         write_data;
    creg_addr_t rt;
    creg_addr_t rd;
    u32         pc;
  } execute_to_memory_t;

  typedef struct packed {
    logic       valid;
    logic       reg_write;
    creg_addr_t wa;
    u32         wd;
    u32         pc;
    logic       misalign;
  } memory_data_t;

  typedef struct packed {
    logic    valid;
    logic    write;
    u32      addr;
    strobe_t strobe;
    u32      data;
  } dbus_req_t;

  typedef struct packed {
    logic addr_ok;
    logic data_ok;
    u32   data;
  } dbus_resp_t;

endpackage

// File: rtl/memory_if.sv
// Data-bus handshake between the MEM stage (master) and memory (slave).
interface memory_if #(
  parameter int unsigned XLEN = 32
);

  logic            dreq_valid;
  logic            dreq_write;
  logic [XLEN-1:0] dreq_addr;
  logic [3:0]      dreq_strobe;
  logic [XLEN-1:0] dreq_data;
  logic            dresp_addr_ok;
  logic            dresp_data_ok;
  logic [XLEN-1:0] dresp_data;

  modport master (
    output dreq_valid,
    output dreq_write,
    output dreq_addr,
    output dreq_strobe,
    output dreq_data,
    input  dresp_addr_ok,
    input  dresp_data_ok,
    input  dresp_data
  );

  modport slave (
    input  dreq_valid,
    input  dreq_write,
    input  dreq_addr,
    input  dreq_strobe,
    input  dreq_data,
    output dresp_addr_ok,
    output dresp_data_ok,
    output dresp_data
  );

endinterface

// File: rtl/memory_dbus_ctrl.sv
// Data-bus controller: slot FSM, valid/addr_ok/data_ok handshake and the
// load-data register. Request fields come straight from the held slot, so
// they stay stable for as long as the request is pending.
module memory_dbus_ctrl
  import memory_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            capture,
  input  logic            start,
  input  logic            is_write,
  input  u32              addr,
  input  u32              wdata,
  output u32              rdata,
  output logic            busy,
  output logic            done,
  memory_if.master        dbus
);

  mem_state_t state_q, state_d;
  u32         rdata_q;
  logic       load_fire;
  dbus_req_t  req;
  dbus_resp_t resp;

  always_comb begin
    resp.addr_ok = dbus.dresp_addr_ok;
    resp.data_ok = dbus.dresp_data_ok;
    resp.data    = dbus.dresp_data;
  end

  // State register; reset also abandons any outstanding transaction.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state: a capture only happens from IDLE/DONE since advance is gated by busy.
  always_comb begin
    state_d   = state_q;
    load_fire = 1'b0;
    unique case (state_q)
      IDLE, DONE: begin
        if (capture) state_d = start ? REQ : DONE;
      end
      REQ: begin
        if (resp.addr_ok) begin
          if (resp.data_ok) begin
            state_d   = DONE;
            load_fire = !is_write;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (resp.data_ok) begin
          state_d   = DONE;
          load_fire = !is_write;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Load-data register, written when a load's data returns.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)         rdata_q <= '0;
    else if (load_fire) rdata_q <= resp.data;
  end

  // Request fields; valid only while the request is not yet accepted.
  always_comb begin
    req        = '0;
    req.valid  = (state_q == REQ);
    req.write  = is_write;
    req.addr   = addr;
    req.strobe = is_write ? STROBE_WORD : '0;
    req.data   = wdata;
  end

  assign dbus.dreq_valid  = req.valid;
  assign dbus.dreq_write  = req.write;
  assign dbus.dreq_addr   = req.addr;
  assign dbus.dreq_strobe = req.strobe;
  assign dbus.dreq_data   = req.data;

  assign rdata = rdata_q;
  assign busy  = (state_q == REQ) || (state_q == WAIT);
  assign done  = (state_q == DONE);

endmodule

// File: rtl/memory.sv
// MEM stage of the 5-stage MIPS pipeline: captures the execute slot, runs
// lw/sw over the data bus, stalls upstream while a transaction is
// outstanding and presents the write-back packet.
module memory
  import memory_pkg::*;
#(
  parameter int unsigned XLEN   = XLEN_W,
  parameter int unsigned REG_AW = REG_AW_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              memory_enable,
  input  logic              ex_valid,
  input  logic              ex_mem_to_reg,
  input  logic              ex_mem_write,
  input  logic              ex_reg_write,
  input  logic              ex_reg_dst,
  input  logic [XLEN-1:0]   ex_alu_result,
  input  logic [XLEN-1:0]   ex_write_data,
  input  logic [REG_AW-1:0] ex_rt,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic [XLEN-1:0]   ex_pc,
  memory_if.master          dbus,
  output logic              mem_valid,
  output logic              mem_reg_write,
  output logic [REG_AW-1:0] mem_wa,
  output logic [XLEN-1:0]   mem_wd,
  output logic [XLEN-1:0]   mem_pc,
  output logic              mem_misalign,
  output logic              mem_stall
);

  execute_to_memory_t ex_in, slot_q;
  memory_data_t       pkt;
  logic               advance, busy, done, start, misalign;
  u32                 rdata;

  // Gather the execute inputs into one slot word.
  always_comb begin
    ex_in            = '0;
    ex_in.valid      = ex_valid;
    ex_in.mem_to_reg = ex_mem_to_reg;
    ex_in.mem_write  = ex_mem_write;
    ex_in.reg_write  = ex_reg_write;
    ex_in.reg_dst    = ex_reg_dst;
    ex_in.alu_result = ex_alu_result;
    ex_in.write_data = ex_write_data;
    ex_in.rt         = ex_rt;
    ex_in.rd         = ex_rd;
    ex_in.pc         = ex_pc;
  end

  assign advance = memory_enable && !busy;
  assign start   = ex_in.valid && (ex_in.mem_to_reg || ex_in.mem_write)
                   && (ex_in.alu_result[1:0] == 2'b00);

  // Slot register: loads on advance, holds otherwise.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)       slot_q <= '0;
    else if (advance) slot_q <= ex_in;
  end

  assign misalign = slot_q.valid && (slot_q.mem_to_reg || slot_q.mem_write)
                    && (slot_q.alu_result[1:0] != 2'b00);

  memory_dbus_ctrl u_dbus_ctrl (
    .clk      (clk),
    .reset    (reset),
    .capture  (advance),
    .start    (start),
    .is_write (slot_q.mem_write),
    .addr     (slot_q.alu_result),
    .wdata    (slot_q.write_data),
    .rdata    (rdata),
    .busy     (busy),
    .done     (done),
    .dbus     (dbus)
  );

  // Write-back packet, presented only once the slot has completed.
  always_comb begin
    pkt = '0;
    if (done) begin
      pkt.valid     = slot_q.valid;
      pkt.reg_write = slot_q.valid && slot_q.reg_write && !misalign;
      pkt.wa        = slot_q.reg_dst ? slot_q.rd : slot_q.rt;
      pkt.wd        = slot_q.mem_to_reg ? rdata : slot_q.alu_result;
      pkt.pc        = slot_q.pc;
      pkt.misalign  = misalign;
    end
  end

  assign mem_valid     = pkt.valid;
  assign mem_reg_write = pkt.reg_write;
  assign mem_wa        = pkt.wa;
  assign mem_wd        = pkt.wd;
  assign mem_pc        = pkt.pc;
  assign mem_misalign  = pkt.misalign;
  assign mem_stall     = busy;

endmodule

// File: tb/tb_memory.sv
// Directed bench for the MEM stage with a packet scoreboard.
module tb_memory;
  import memory_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        memory_enable, ex_valid, ex_mem_to_reg, ex_mem_write;
  logic        ex_reg_write, ex_reg_dst;
  logic [31:0] ex_alu_result, ex_write_data, ex_pc;
  logic [4:0]  ex_rt, ex_rd;
  logic        mem_valid, mem_reg_write, mem_misalign, mem_stall;
  logic [4:0]  mem_wa;
  logic [31:0] mem_wd, mem_pc;

  memory_if #(.XLEN(32)) bus ();

  memory #(.XLEN(32), .REG_AW(5)) dut (
    .clk           (clk),
    .reset         (reset),
    .memory_enable (memory_enable),
    .ex_valid      (ex_valid),
    .ex_mem_to_reg (ex_mem_to_reg),
    .ex_mem_write  (ex_mem_write),
    .ex_reg_write  (ex_reg_write),
    .ex_reg_dst    (ex_reg_dst),
    .ex_alu_result (ex_alu_result),
    .ex_write_data (ex_write_data),
    .ex_rt         (ex_rt),
    .ex_rd         (ex_rd),
    .ex_pc         (ex_pc),
    .dbus          (bus.master),
    .mem_valid     (mem_valid),
    .mem_reg_write (mem_reg_write),
    .mem_wa        (mem_wa),
    .mem_wd        (mem_wd),
    .mem_pc        (mem_pc),
    .mem_misalign  (mem_misalign),
    .mem_stall     (mem_stall)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rw;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [31:0] pc;
    logic        mis;
    logic        chk_wd;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;
  int   req_cycles = 0;
  int   r0;

  // Count clock edges on which a request is presented.
  always @(posedge clk) if (bus.dreq_valid === 1'b1) req_cycles++;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive_ex(input logic v, input logic m2r, input logic mw, input logic rw,
                          input logic rdst, input logic [31:0] alu, input logic [31:0] wd,
                          input logic [4:0] rt, input logic [4:0] rd, input logic [31:0] pc);
    memory_enable = 1'b1;
    ex_valid      = v;
    ex_mem_to_reg = m2r;
    ex_mem_write  = mw;
    ex_reg_write  = rw;
    ex_reg_dst    = rdst;
    ex_alu_result = alu;
    ex_write_data = wd;
    ex_rt         = rt;
    ex_rd         = rd;
    ex_pc         = pc;
  endtask

  task automatic idle_ex();
    memory_enable = 1'b0;
    ex_valid      = 1'b0;
    ex_mem_to_reg = 1'b0;
    ex_mem_write  = 1'b0;
    ex_reg_write  = 1'b0;
    ex_reg_dst    = 1'b0;
    ex_alu_result = '0;
    ex_write_data = '0;
    ex_rt         = '0;
    ex_rd         = '0;
    ex_pc         = '0;
  endtask

  task automatic expect_pkt(input string tag);
    exp_t e;
    chk({tag, "_sb_nonempty"}, 32'(exp_q.size() != 0), 1);
    if (exp_q.size() == 0) return;
    e = exp_q.pop_front();
    chk({tag, "_valid"}, 32'(mem_valid), 1);
    chk({tag, "_reg_write"}, 32'(mem_reg_write), 32'(e.rw));
    chk({tag, "_wa"}, 32'(mem_wa), 32'(e.wa));
    if (e.chk_wd) chk({tag, "_wd"}, mem_wd, e.wd);
    chk({tag, "_pc"}, mem_pc, e.pc);
    chk({tag, "_misalign"}, 32'(mem_misalign), 32'(e.mis));
  endtask

  initial begin
    idle_ex();
    bus.dresp_addr_ok = 1'b0;
    bus.dresp_data_ok = 1'b0;
    bus.dresp_data    = '0;
    repeat (2) tick();

    // reset state
    chk("rst_mem_valid", 32'(mem_valid), 0);
    chk("rst_reg_write", 32'(mem_reg_write), 0);
    chk("rst_wa", 32'(mem_wa), 0);
    chk("rst_wd", mem_wd, 0);
    chk("rst_pc", mem_pc, 0);
    chk("rst_misalign", 32'(mem_misalign), 0);
    chk("rst_stall", 32'(mem_stall), 0);
    chk("rst_dreq_valid", 32'(bus.dreq_valid), 0);
    chk("rst_dreq_write", 32'(bus.dreq_write), 0);
    chk("rst_dreq_addr", bus.dreq_addr, 0);
    chk("rst_dreq_strobe", 32'(bus.dreq_strobe), 0);
    chk("rst_dreq_data", bus.dreq_data, 0);
    reset = 1'b1;
    tick();

    // ALU op: packet the cycle after capture, no bus traffic
    r0 = req_cycles;
    drive_ex(1, 0, 0, 1, 0, 32'h0000_0010, 32'h0, 5'd5, 5'd0, 32'h400);
    exp_q.push_back('{1'b1, 5'd5, 32'h10, 32'h400, 1'b0, 1'b1});
    tick();
    idle_ex();
    expect_pkt("alu");
    chk("alu_stall", 32'(mem_stall), 0);
    tick();
    chk("alu_no_req", req_cycles, r0);

    // lw with addr_ok and data_ok together: one stall cycle
    drive_ex(1, 1, 0, 1, 0, 32'h100, 32'h0, 5'd8, 5'd0, 32'h404);
    exp_q.push_back('{1'b1, 5'd8, 32'hDEAD_BEEF, 32'h404, 1'b0, 1'b1});
    tick();
    idle_ex();
    chk("lw_req_valid", 32'(bus.dreq_valid), 1);
    chk("lw_req_addr", bus.dreq_addr, 32'h100);
    chk("lw_req_write", 32'(bus.dreq_write), 0);
    chk("lw_req_strobe", 32'(bus.dreq_strobe), 0);
    chk("lw_stall", 32'(mem_stall), 1);
    bus.dresp_addr_ok = 1'b1;
    bus.dresp_data_ok = 1'b1;
    bus.dresp_data    = 32'hDEAD_BEEF;
    tick();
    bus.dresp_addr_ok = 1'b0;
    bus.dresp_data_ok = 1'b0;
    bus.dresp_data    = '0;
    expect_pkt("lw");
    chk("lw_stall_done", 32'(mem_stall), 0);

    // sw: addr_ok after 3 waits, data_ok 2 cycles later; next op waits upstream
    r0 = req_cycles;
    drive_ex(1, 0, 1, 0, 0, 32'h104, 32'h1234, 5'd9, 5'd0, 32'h408);
    exp_q.push_back('{1'b0, 5'd9, 32'h104, 32'h408, 1'b0, 1'b1});
    tick();
    drive_ex(1, 0, 0, 1, 1, 32'h77, 32'h0, 5'd2, 5'd11, 32'h40C);
    exp_q.push_back('{1'b1, 5'd11, 32'h77, 32'h40C, 1'b0, 1'b1});
    for (int k = 0; k < 4; k++) begin
      chk("sw_req_valid", 32'(bus.dreq_valid), 1);
      chk("sw_req_addr", bus.dreq_addr, 32'h104);
      chk("sw_req_data", bus.dreq_data, 32'h1234);
      chk("sw_req_strobe", 32'(bus.dreq_strobe), 32'hF);
      chk("sw_req_write", 32'(bus.dreq_write), 1);
      chk("sw_req_stall", 32'(mem_stall), 1);
      chk("sw_req_no_pkt", 32'(mem_valid), 0);
      if (k == 3) bus.dresp_addr_ok = 1'b1;
      tick();
      bus.dresp_addr_ok = 1'b0;
    end
    for (int k = 0; k < 2; k++) begin
      chk("sw_wait_valid", 32'(bus.dreq_valid), 0);
      chk("sw_wait_stall", 32'(mem_stall), 1);
      if (k == 1) bus.dresp_data_ok = 1'b1;
      tick();
      bus.dresp_data_ok = 1'b0;
    end
    expect_pkt("sw");
    chk("sw_stall_done", 32'(mem_stall), 0);
    chk("sw_req_cycles", req_cycles - r0, 4);
    tick();
    idle_ex();
    expect_pkt("alu_after_sw");

    // misaligned lw: no request, no stall, no write-back
    r0 = req_cycles;
    drive_ex(1, 1, 0, 1, 0, 32'h102, 32'h0, 5'd3, 5'd0, 32'h410);
    exp_q.push_back('{1'b0, 5'd3, 32'h0, 32'h410, 1'b1, 1'b0});
    tick();
    idle_ex();
    expect_pkt("lw_mis");
    chk("lw_mis_stall", 32'(mem_stall), 0);
    chk("lw_mis_dreq", 32'(bus.dreq_valid), 0);
    tick();
    chk("lw_mis_no_req", req_cycles, r0);

    // reset while a load is waiting for data
    drive_ex(1, 1, 0, 1, 0, 32'h200, 32'h0, 5'd4, 5'd0, 32'h414);
    tick();
    idle_ex();
    chk("rw_req_valid", 32'(bus.dreq_valid), 1);
    bus.dresp_addr_ok = 1'b1;
    tick();
    bus.dresp_addr_ok = 1'b0;
    chk("rw_wait_dreq", 32'(bus.dreq_valid), 0);
    chk("rw_wait_stall", 32'(mem_stall), 1);
    #2 reset = 1'b0;
    #1;
    chk("rw_async_dreq", 32'(bus.dreq_valid), 0);
    chk("rw_async_valid", 32'(mem_valid), 0);
    chk("rw_async_stall", 32'(mem_stall), 0);
    tick();
    reset = 1'b1;
    bus.dresp_data_ok = 1'b1;
    bus.dresp_data    = 32'hBAD0_BAD0;
    tick();
    bus.dresp_data_ok = 1'b0;
    bus.dresp_data    = '0;
    chk("rw_late_valid", 32'(mem_valid), 0);
    chk("rw_late_reg_write", 32'(mem_reg_write), 0);
    chk("rw_late_stall", 32'(mem_stall), 0);
    chk("rw_late_dreq", 32'(bus.dreq_valid), 0);

    // next lw after reset: addr_ok at once, data one cycle later
    drive_ex(1, 1, 0, 1, 0, 32'h300, 32'h0, 5'd6, 5'd0, 32'h418);
    exp_q.push_back('{1'b1, 5'd6, 32'hCAFE_F00D, 32'h418, 1'b0, 1'b1});
    tick();
    idle_ex();
    chk("lw2_req_valid", 32'(bus.dreq_valid), 1);
    chk("lw2_req_addr", bus.dreq_addr, 32'h300);
    bus.dresp_addr_ok = 1'b1;
    tick();
    bus.dresp_addr_ok = 1'b0;
    chk("lw2_wait_stall", 32'(mem_stall), 1);
    bus.dresp_data_ok = 1'b1;
    bus.dresp_data    = 32'hCAFE_F00D;
    tick();
    bus.dresp_data_ok = 1'b0;
    bus.dresp_data    = '0;
    expect_pkt("lw_after_rst");

    // bubble followed by two cycles without advance
    r0 = req_cycles;
    drive_ex(0, 0, 1, 0, 0, 32'h500, 32'hAA, 5'd7, 5'd0, 32'h41C);
    tick();
    idle_ex();
    for (int k = 0; k < 3; k++) begin
      chk("bub_valid", 32'(mem_valid), 0);
      chk("bub_reg_write", 32'(mem_reg_write), 0);
      chk("bub_misalign", 32'(mem_misalign), 0);
      chk("bub_dreq", 32'(bus.dreq_valid), 0);
      chk("bub_stall", 32'(mem_stall), 0);
      tick();
    end
    chk("bub_no_req", req_cycles, r0);
    chk("sb_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/memory.md
Name: memory

Overview:
- MEM stage of the 5-stage MIPS pipeline.
- Sits directly downstream of execute. Consumes its ALU result, store data and control bits.
- Issues lw/sw over the data bus with a valid/addr_ok/data_ok handshake.
- Presents the register write-back packet to writeback and stalls the pipeline while a bus transaction is outstanding.

Parameters:
- XLEN, 32, data and address width.
- REG_AW, 5, register address width.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- memory_enable  in  1  pipeline advance permission from hazard control
- ex_valid  in  1  execute slot holds a real instruction
- ex_mem_to_reg  in  1  lw
- ex_mem_write  in  1  sw
- ex_reg_write  in  1  instruction writes a register
- ex_reg_dst  in  1  1 selects rd, 0 selects rt
- ex_alu_result  in  XLEN  effective address or ALU value
- ex_write_data  in  XLEN  rt value for sw
- ex_rt, ex_rd  in  REG_AW  register numbers
- ex_pc  in  XLEN  instruction pc
- dreq_valid  out  1  bus request
- dreq_write  out  1  request is a store
- dreq_addr  out  XLEN  word address
- dreq_strobe  out  4  byte enables
- dreq_data  out  XLEN  store data
- dresp_addr_ok  in  1  request accepted
- dresp_data_ok  in  1  data returned / store done
- dresp_data  in  XLEN  load data
- mem_valid  out  1  output packet valid
- mem_reg_write  out  1  write-back enable
- mem_wa  out  REG_AW  write-back register
- mem_wd  out  XLEN  write-back data
- mem_pc  out  XLEN  pc of the packet
- mem_misalign  out  1  lw/sw address not word aligned
- mem_stall  out  1  freeze upstream stages

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE and all internal registers cleared.
  - All outputs 0; dreq_valid drops immediately.
  - A data_ok arriving after reset is ignored. The bus is reset with the core.
- Advance: advance = memory_enable && !mem_stall.
  - At posedge with advance, latch all ex_* signals into the slot register.
  - Without advance, the slot holds.
- FSM states: IDLE, REQ, WAIT, DONE. Transitions at posedge when a new slot is captured:
  - ex_valid=0: capture a bubble, go to DONE, mem_valid=0.
  - Valid non-memory op: go to DONE.
  - Valid lw/sw with ex_alu_result[1:0]==0: go to REQ.
  - Valid lw/sw with ex_alu_result[1:0]!=0: go to DONE. No bus request, mem_misalign=1, mem_reg_write=0.
- REQ state:
  - dreq_valid=1 with addr, write, strobe and data stable until dresp_addr_ok.
  - addr_ok && data_ok in the same cycle: go to DONE.
  - addr_ok only: go to WAIT.
  - Otherwise: stay in REQ.
- WAIT state:
  - dreq_valid=0.
  - On data_ok, latch dresp_data (lw only) and go to DONE.
- DONE/IDLE: hold until the next advance. A new capture overrides the current state.
- Stall: mem_stall = (state==REQ || state==WAIT).
- Bus fields:
  - dreq_write = mem_write.
  - dreq_strobe = 4'b1111 for sw, 4'b0000 for lw.
  - dreq_addr = alu_result.
  - dreq_data = write_data.
- Output packet, valid only in DONE:
  - mem_valid = slot valid.
  - mem_wa = reg_dst ? rd : rt.
  - mem_wd = mem_to_reg ? load_data : alu_result.
  - mem_reg_write = valid && reg_write && !misalign.
  - mem_pc = slot pc.
  - In IDLE, REQ and WAIT, mem_valid=0 and mem_reg_write=0.
- Latency:
  - Non-memory op: packet valid the cycle after capture.
  - lw/sw: 1 + (cycles to addr_ok) + (cycles to data_ok, 0 if same cycle). Minimum 2 cycles.
- Simultaneous events:
  - memory_enable is ignored while stalled.
  - data_ok while in REQ without addr_ok is ignored. The bus never does this.
  - Only one transaction is outstanding at a time.

Decomposition:
- pipes package:
  - mem_state_t enum {IDLE, REQ, WAIT, DONE}.
  - memory_data_t struct (valid, reg_write, wa, wd, pc, misalign).
  - A packed execute_to_memory_t struct grouping the ex_* inputs.
- common package:
  - u32, creg_addr_t, strobe_t.
  - dbus request/response structs for the port lists.
- One sub-module, dbus_ctrl: owns the FSM, handshake and load-data register. It exposes start, is_write, addr, wdata, rdata, busy and done.

Test Plan:
- ALU op (addi result 0x0000_0010, rt=5), memory_enable=1 -> next cycle mem_valid=1, mem_wa=5, mem_wd=0x10, mem_stall=0, dreq_valid never asserted.
- lw addr 0x100, addr_ok and data_ok same cycle as request, dresp_data=0xDEAD_BEEF -> one stall cycle, then mem_wd=0xDEADBEEF, mem_reg_write=1.
- sw addr 0x104, data 0x1234, addr_ok after 3 cycles, data_ok 2 cycles later -> dreq stable for 4 cycles with strobe 4'hF and write=1; stall for 6 cycles; mem_reg_write=0.
- lw addr 0x102 -> no dreq_valid, mem_misalign=1, mem_reg_write=0, no stall.
- reset pulled low while in WAIT -> dreq_valid=0 and mem_valid=0 immediately; a data_ok after release causes no write-back; the next lw completes normally.
- Bubble (ex_valid=0) followed by memory_enable=0 for 2 cycles -> outputs hold with mem_valid=0 and no bus activity.
